// File: rtl/mcu_pkg.sv
// Shared encodings for the MCU sequencer and the mux array it steers.
// The state codes are decoded directly by MUX_ARRAY, so they must not change.
package mcu_pkg;

   typedef enum logic [1:0] {
      ST_LOAD = 2'b00,
      ST_RUN  = 2'b01,
      ST_OUT  = 2'b10,
      ST_IDLE = 2'b11
   } mcu_state_t;

   // First memory of each write-back set (set 0 when substate=0, set 1 when substate=1).
   localparam int WB_BASE0 = 0;
   localparam int WB_BASE1 = 2;

endpackage

// File: rtl/mcu_addr_delay.sv
// Fixed-depth shift register carrying {valid, address}.
// It aligns the BRAM write-back with the read address plus the convolver latency.
module mcu_addr_delay #(
   parameter int DEPTH = 3,
   parameter int AW    = 9
) (
   input  logic          clk,
   input  logic          srst,
   input  logic          in_valid,
   input  logic [AW-1:0] in_addr,
   output logic          out_valid,
   output logic [AW-1:0] out_addr
);

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_stage
         logic          valid_reg;
         logic [AW-1:0] addr_reg;
         logic          valid_next;
         logic [AW-1:0] addr_next;

         if (gi == 0) begin : g_head
            assign valid_next = in_valid;
            assign addr_next  = in_addr;
         end else begin : g_link
            assign valid_next = g_stage[gi-1].valid_reg;
            assign addr_next  = g_stage[gi-1].addr_reg;
         end

         always_ff @(posedge clk) begin
            if (srst) begin
               valid_reg <= 1'b0;
               addr_reg  <= '0;
            end else begin
               valid_reg <= valid_next;
               addr_reg  <= addr_next;
            end
         end
      end
   endgenerate

   assign out_valid = g_stage[DEPTH-1].valid_reg;
   assign out_addr  = g_stage[DEPTH-1].addr_reg;

endmodule

// File: rtl/mcu_sequencer.sv
// Per-stripe control FSM (LOAD -> RUN -> OUT) for the convolver memory mux array.
// Optional cycle counter output o_cycleCnt is built when MCU_CYCLE_CNT_EN is defined.
module mcu_sequencer
   import mcu_pkg::*;
#(
   parameter int N           = 2,
   parameter int BITS_IMAGEN = 11,
   parameter int IMG_WIDTH   = 440,
   parameter int BITS_ADDR   = $clog2(IMG_WIDTH),
   parameter int CONV_LAT    = 2
) (
   input  logic                        i_CLK,
   input  logic                        i_reset,
   input  logic                        i_start,
   input  logic                        i_lastStripe,
   input  logic                        i_inValid,
   output logic                        o_inReady,
   input  logic                        i_outReady,
   output logic                        o_outValid,
   output logic [1:0]                  o_state,
   output logic                        o_substate,
   output logic [$clog2(N+2)-1:0]      o_memSelect,
   output logic [BITS_ADDR-1:0]        o_rdAddr,
   output logic [BITS_ADDR-1:0]        o_wrAddr,
   output logic [N+1:0]                o_wrEn,
   output logic                        o_busy,
   output logic                        o_done
`ifdef MCU_CYCLE_CNT_EN
   ,
   output logic [31:0]                 o_cycleCnt
`endif
);

   localparam int NM      = N + 2;
   localparam int SW      = $clog2(NM);
   localparam int RUN_CYC = IMG_WIDTH + 1 + CONV_LAT;
   localparam int RCW     = $clog2(RUN_CYC);
   localparam logic [BITS_ADDR-1:0] ADDR_LAST = BITS_ADDR'(IMG_WIDTH - 1);

   generate
      if ((N < 2) || (N % 2 != 0) || (BITS_IMAGEN < 1)) begin : g_param_check
         $error("mcu_sequencer: N must be even and >= 2, BITS_IMAGEN >= 1");
      end
   endgenerate

   mcu_state_t         state_reg;
   logic               substate_reg;
   logic               first_reg;
   logic [SW-1:0]      mem_sel_reg;
   logic [BITS_ADDR-1:0] rd_addr_reg;
   logic [BITS_ADDR-1:0] wr_addr_reg;
   logic               in_ready_reg;
   logic               out_valid_reg;
   logic               busy_reg;
   logic               done_reg;
   logic               last_stripe_reg;
   logic [RCW-1:0]     run_cnt_reg;

   logic               srst;
   logic               in_hs;
   logic               out_hs;
   logic               out_last;
   logic               rd_active;
   logic [SW-1:0]      wb_base_sel;
   logic [SW-1:0]      next_base_sel;
   logic [SW-1:0]      load_end_sel;
   logic [SW-1:0]      out_end_sel;
   logic [SW-1:0]      out_sel_adv;
   logic [BITS_ADDR-1:0] out_addr_adv;
   logic [NM-1:0]      wb_mask;
   logic [NM-1:0]      load_we;
   logic               dly_valid;
   logic [BITS_ADDR-1:0] dly_addr;

   assign srst          = ~i_reset;
   assign in_hs         = (state_reg == ST_LOAD) && i_inValid && in_ready_reg;
   assign out_hs        = (state_reg == ST_OUT) && out_valid_reg && i_outReady;
   assign rd_active     = (state_reg == ST_RUN) && (run_cnt_reg < RCW'(IMG_WIDTH));
   assign wb_base_sel   = substate_reg ? SW'(WB_BASE1) : SW'(WB_BASE0);
   assign next_base_sel = substate_reg ? SW'(WB_BASE0) : SW'(WB_BASE1);
   assign load_end_sel  = first_reg ? SW'(NM - 1) : wb_base_sel + SW'(N - 1);
   assign out_end_sel   = wb_base_sel + SW'(N - 1);
   assign out_last      = (mem_sel_reg == out_end_sel) && (rd_addr_reg == ADDR_LAST);
   assign out_addr_adv  = (rd_addr_reg == ADDR_LAST) ? '0 : rd_addr_reg + BITS_ADDR'(1);
   assign out_sel_adv   = (rd_addr_reg == ADDR_LAST) ? mem_sel_reg + SW'(1) : mem_sel_reg;

   genvar gi;
   generate
      for (gi = 0; gi < NM; gi++) begin : g_we
         localparam bit IN_SET0 = (gi >= WB_BASE0) && (gi < WB_BASE0 + N);
         localparam bit IN_SET1 = (gi >= WB_BASE1) && (gi < WB_BASE1 + N);
         assign wb_mask[gi] = substate_reg ? IN_SET1 : IN_SET0;
         assign load_we[gi] = in_hs && (mem_sel_reg == SW'(gi));
      end
   endgenerate

   mcu_addr_delay #(
      .DEPTH (1 + CONV_LAT),
      .AW    (BITS_ADDR)
   ) u_wb_delay (
      .clk       (i_CLK),
      .srst      (srst),
      .in_valid  (rd_active),
      .in_addr   (rd_addr_reg),
      .out_valid (dly_valid),
      .out_addr  (dly_addr)
   );

   // OUT advances the read address in the handshake cycle itself, so the BRAM
   // output is replaced exactly once per accepted word and held during a stall.
   assign o_rdAddr    = (out_hs && !out_last) ? out_addr_adv : rd_addr_reg;
   assign o_memSelect = (out_hs && !out_last) ? out_sel_adv : mem_sel_reg;
   assign o_wrEn      = load_we | (((state_reg == ST_RUN) && dly_valid) ? wb_mask : '0);
   assign o_wrAddr    = (state_reg == ST_RUN) ? dly_addr : wr_addr_reg;
   assign o_state     = state_reg;
   assign o_substate  = substate_reg;
   assign o_inReady   = in_ready_reg;
   assign o_outValid  = out_valid_reg;
   assign o_busy      = busy_reg;
   assign o_done      = done_reg;

   always_ff @(posedge i_CLK) begin
      if (!i_reset) begin
         state_reg       <= ST_IDLE;
         substate_reg    <= 1'b0;
         first_reg       <= 1'b1;
         mem_sel_reg     <= '0;
         rd_addr_reg     <= '0;
         wr_addr_reg     <= '0;
         in_ready_reg    <= 1'b0;
         out_valid_reg   <= 1'b0;
         busy_reg        <= 1'b0;
         done_reg        <= 1'b0;
         last_stripe_reg <= 1'b0;
         run_cnt_reg     <= '0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (i_start) begin
                  state_reg    <= ST_LOAD;
                  in_ready_reg <= 1'b1;
                  busy_reg     <= 1'b1;
                  mem_sel_reg  <= first_reg ? '0 : wb_base_sel;
                  wr_addr_reg  <= '0;
               end
            end
            ST_LOAD: begin
               if (in_hs) begin
                  if (wr_addr_reg == ADDR_LAST) begin
                     wr_addr_reg <= '0;
                     if (mem_sel_reg == load_end_sel) begin
                        state_reg    <= ST_RUN;
                        in_ready_reg <= 1'b0;
                        run_cnt_reg  <= '0;
                        rd_addr_reg  <= '0;
                     end else begin
                        mem_sel_reg <= mem_sel_reg + SW'(1);
                     end
                  end else begin
                     wr_addr_reg <= wr_addr_reg + BITS_ADDR'(1);
                  end
               end
            end
            ST_RUN: begin
               run_cnt_reg <= run_cnt_reg + RCW'(1);
               if (rd_active) begin
                  rd_addr_reg <= (rd_addr_reg == ADDR_LAST) ? '0 : rd_addr_reg + BITS_ADDR'(1);
               end
               if (run_cnt_reg == RCW'(RUN_CYC - 1)) begin
                  state_reg       <= ST_OUT;
                  mem_sel_reg     <= wb_base_sel;
                  rd_addr_reg     <= '0;
                  out_valid_reg   <= 1'b0;
                  last_stripe_reg <= i_lastStripe;
               end
            end
            ST_OUT: begin
               if (!out_valid_reg) begin
                  out_valid_reg <= 1'b1;
               end else if (out_hs) begin
                  if (out_last) begin
                     out_valid_reg <= 1'b0;
                     rd_addr_reg   <= '0;
                     if (last_stripe_reg) begin
                        state_reg   <= ST_IDLE;
                        busy_reg    <= 1'b0;
                        done_reg    <= 1'b1;
                        mem_sel_reg <= '0;
                     end else begin
                        state_reg    <= ST_LOAD;
                        substate_reg <= ~substate_reg;
                        first_reg    <= 1'b0;
                        mem_sel_reg  <= next_base_sel;
                        wr_addr_reg  <= '0;
                        in_ready_reg <= 1'b1;
                     end
                  end else begin
                     rd_addr_reg <= out_addr_adv;
                     mem_sel_reg <= out_sel_adv;
                  end
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

`ifdef MCU_CYCLE_CNT_EN
   logic [31:0] cycle_cnt_reg;

   always_ff @(posedge i_CLK) begin
      if (!i_reset) begin
         cycle_cnt_reg <= '0;
      end else if ((state_reg == ST_IDLE) && i_start) begin
         cycle_cnt_reg <= '0;
      end else if (busy_reg && (cycle_cnt_reg != 32'hFFFF_FFFF)) begin
         cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
      end
   end

   assign o_cycleCnt = cycle_cnt_reg;
`endif

endmodule

// File: tb/tb_mcu_sequencer.sv
// Randomized-handshake bench for mcu_sequencer (N=2, IMG_WIDTH=8, CONV_LAT=2).
// Expected addresses, enables and phase lengths are derived from stripe arithmetic.
module tb_mcu_sequencer;

   localparam int N  = 2;
   localparam int W  = 8;
   localparam int CL = 2;
   localparam int NM = N + 2;

   logic       i_CLK = 1'b0;
   logic       i_reset;
   logic       i_start;
   logic       i_lastStripe;
   logic       i_inValid;
   logic       o_inReady;
   logic       i_outReady;
   logic       o_outValid;
   logic [1:0] o_state;
   logic       o_substate;
   logic [1:0] o_memSelect;
   logic [2:0] o_rdAddr;
   logic [2:0] o_wrAddr;
   logic [3:0] o_wrEn;
   logic       o_busy;
   logic       o_done;
`ifdef MCU_CYCLE_CNT_EN
   logic [31:0] o_cycleCnt;
`endif

   int errors = 0;
   int checks = 0;

   always #5 i_CLK = ~i_CLK;

   mcu_sequencer #(
      .N         (N),
      .IMG_WIDTH (W),
      .CONV_LAT  (CL)
   ) dut (
      .i_CLK        (i_CLK),
      .i_reset      (i_reset),
      .i_start      (i_start),
      .i_lastStripe (i_lastStripe),
      .i_inValid    (i_inValid),
      .o_inReady    (o_inReady),
      .i_outReady   (i_outReady),
      .o_outValid   (o_outValid),
      .o_state      (o_state),
      .o_substate   (o_substate),
      .o_memSelect  (o_memSelect),
      .o_rdAddr     (o_rdAddr),
      .o_wrAddr     (o_wrAddr),
      .o_wrEn       (o_wrEn),
      .o_busy       (o_busy),
      .o_done       (o_done)
`ifdef MCU_CYCLE_CNT_EN
      ,
      .o_cycleCnt   (o_cycleCnt)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_CLK);
      #1;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_state"}, 32'(o_state), 32'd3);
      check({tag, "_wren"}, 32'(o_wrEn), 32'd0);
      check({tag, "_busy"}, 32'(o_busy), 32'd0);
      check({tag, "_rdaddr"}, 32'(o_rdAddr), 32'd0);
      check({tag, "_wraddr"}, 32'(o_wrAddr), 32'd0);
      check({tag, "_memsel"}, 32'(o_memSelect), 32'd0);
      check({tag, "_inready"}, 32'(o_inReady), 32'd0);
      check({tag, "_outvalid"}, 32'(o_outValid), 32'd0);
   endtask

   // Row k/W of the load goes to memory base+k/W, word k%W.
   task automatic do_load(input int rows, input int base, input bit rnd);
      int k = 0;
      int cyc = 0;
      int sel;
      while (k < rows * W && cyc < 2000) begin
         i_inValid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         #1;
         check("load_state", 32'(o_state), 32'd0);
         check("load_ready", 32'(o_inReady), 32'd1);
         if (i_inValid) begin
            sel = base + k / W;
            check("load_sel", 32'(o_memSelect), 32'(sel));
            check("load_wraddr", 32'(o_wrAddr), 32'(k % W));
            check("load_wren", 32'(o_wrEn), 32'(1 << sel));
            k++;
         end else begin
            check("load_nowren", 32'(o_wrEn), 32'd0);
         end
         tick();
         cyc++;
      end
      check("load_count", 32'(k), 32'(rows * W));
      i_inValid = 1'b1;
   endtask

   // Reads 0..W-1 back to back; write-back trails by 1+CL cycles over the active set.
   task automatic do_run(input int sub, input bit last);
      logic [3:0] mask;
      mask = 4'(((1 << N) - 1) << (sub ? 2 : 0));
      i_lastStripe = last;
      for (int i = 0; i < W + 1 + CL; i++) begin
         i_start   = (i == 4);
         i_inValid = 1'b1;
         #1;
         check("run_state", 32'(o_state), 32'd1);
         check("run_ready", 32'(o_inReady), 32'd0);
         check("run_sub", 32'(o_substate), 32'(sub));
         if (i < W) check("run_rdaddr", 32'(o_rdAddr), 32'(i));
         if (i >= 1 + CL && i <= W + CL) begin
            check("run_wren", 32'(o_wrEn), 32'(mask));
            check("run_wraddr", 32'(o_wrAddr), 32'(i - 1 - CL));
         end else begin
            check("run_nowren", 32'(o_wrEn), 32'd0);
         end
         tick();
      end
      i_start   = 1'b0;
      i_inValid = 1'b0;
   endtask

   // Data seen at a handshake belongs to the address presented one cycle earlier.
   task automatic do_out(input int base, input bit last, input int next_sub);
      int j = 0;
      int cyc = 0;
      bit pend = 0;
      logic [1:0] psel = '0;
      logic [2:0] paddr = '0;
      while (j < N * W && cyc < 2000) begin
         i_outReady = 1'($urandom_range(0, 1));
         if (cyc == 1) i_lastStripe = !last;
         #1;
         check("out_state", 32'(o_state), 32'd2);
         check("out_nowren", 32'(o_wrEn), 32'd0);
         if (cyc == 0) check("out_first_invalid", 32'(o_outValid), 32'd0);
         if (pend) check("out_valid_held", 32'(o_outValid), 32'd1);
         if (o_outValid) begin
            if (i_outReady) begin
               check("out_sel", 32'(psel), 32'(base + j / W));
               check("out_addr", 32'(paddr), 32'(j % W));
               j++;
               pend = 0;
            end else begin
               check("out_hold_sel", 32'(o_memSelect), 32'(psel));
               check("out_hold_addr", 32'(o_rdAddr), 32'(paddr));
               pend = 1;
            end
         end
         psel  = o_memSelect;
         paddr = o_rdAddr;
         tick();
         cyc++;
      end
      check("out_count", 32'(j), 32'(N * W));
      i_outReady = 1'b0;
      #1;
      if (last) begin
         check("done_pulse", 32'(o_done), 32'd1);
         check("done_state", 32'(o_state), 32'd3);
         check("done_busy", 32'(o_busy), 32'd0);
         tick();
         check("done_once", 32'(o_done), 32'd0);
         check("done_idle", 32'(o_state), 32'd3);
      end else begin
         check("next_state", 32'(o_state), 32'd0);
         check("next_sub", 32'(o_substate), 32'(next_sub));
         check("next_ready", 32'(o_inReady), 32'd1);
         check("next_outvalid", 32'(o_outValid), 32'd0);
         check("next_done", 32'(o_done), 32'd0);
      end
   endtask

   initial begin
      i_reset      = 1'b0;
      i_start      = 1'b0;
      i_lastStripe = 1'b0;
      i_inValid    = 1'b0;
      i_outReady   = 1'b0;
      tick();
      tick();
      tick();
      check_idle("rst");
      check("rst_sub", 32'(o_substate), 32'd0);
      check("rst_done", 32'(o_done), 32'd0);
`ifdef MCU_CYCLE_CNT_EN
      check("rst_cyclecnt", o_cycleCnt, 32'd0);
`endif
      i_reset = 1'b1;
      tick();
      check_idle("post_rst");

      // First stripe interrupted by reset a few cycles into RUN.
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      do_load(NM, 0, 1'b0);
      i_inValid = 1'b0;
      tick();
      tick();
      tick();
      i_reset = 1'b0;
      for (int r = 0; r < 3; r++) begin
         tick();
         check_idle("midrun_rst");
      end
      i_reset = 1'b1;
      tick();
      check_idle("midrun_release");

      // Full first stripe, then the final stripe on the other write-back set.
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      do_load(NM, 0, 1'b1);
      do_run(0, 1'b0);
      do_out(0, 1'b0, 1);
      do_load(N, 2, 1'b1);
      do_run(1, 1'b1);
      do_out(2, 1'b1, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
